// File: rtl/clkdiv_calib_pkg.sv
// Shared types and helpers for the CLKDIV/IDES8 word-alignment controller.
package clkdiv_calib_pkg;

  typedef enum logic [2:0] {
    StHold,
    StSettle,
    StCheck,
    StSlip,
    StSlipWait,
    StLocked,
    StFail
  } state_e;

  localparam logic [7:0] TrainDefault = 8'hB4;

  // Width of the shared down-timer: holds any load value up to max(a, b, c) - 1.
  function automatic int unsigned timer_width(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/clkdiv_calib_ctrl_if.sv
// Word input, restart request and CLKDIV control/status outputs of the alignment controller.
interface clkdiv_calib_ctrl_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned SW = 3
);

  logic [W-1:0]  word_in;
  logic          word_valid;
  logic          realign;
  logic          clkdiv_resetn;
  logic          calib;
  logic          locked;
  logic          fail;
  logic [SW-1:0] slip_cnt;

  // master: the controller; slave: the deserialiser/system side.
  modport master (
    input  word_in, word_valid, realign,
    output clkdiv_resetn, calib, locked, fail, slip_cnt
  );

  modport slave (
    output word_in, word_valid, realign,
    input  clkdiv_resetn, calib, locked, fail, slip_cnt
  );

endinterface

// File: rtl/cal_timer.sv
// Loadable down-counter that stops at zero; load wins over counting.
module cal_timer #(
  parameter int unsigned     Width    = 5,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= ResetVal;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clkdiv_calib_ctrl.sv
// Holds the CLKDIV in reset, releases it, then bit-slips via calib until the training word
// is seen MATCH_CNT times in a row or the slip budget is spent.
module clkdiv_calib_ctrl
  import clkdiv_calib_pkg::*;
#(
  parameter int unsigned     DIV       = 8,
  parameter logic [DIV-1:0]  TRAIN     = DIV'(TrainDefault),
  parameter int unsigned     RST_HOLD  = 16,
  parameter int unsigned     SETTLE    = 32,
  parameter int unsigned     SLIP_WAIT = 16,
  parameter int unsigned     MATCH_CNT = 4,
  parameter int unsigned     MAX_SLIP  = DIV - 1
) (
  input  logic                clkin,
  input  logic                resetn,
  clkdiv_calib_ctrl_if.master bus
);

  localparam int unsigned TW = timer_width(RST_HOLD, SETTLE, SLIP_WAIT);
  localparam int unsigned SW = (MAX_SLIP > 0) ? $clog2(MAX_SLIP + 1) : 1;
  localparam int unsigned MW = $clog2(MATCH_CNT + 1);

  state_e          state_q, state_d;
  logic [MW-1:0]   match_q, match_d;
  logic [SW-1:0]   slip_q, slip_d;
  logic            rstn_q, calib_q, locked_q, fail_q;
  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_zero;

  cal_timer #(
    .Width    (TW),
    .ResetVal (TW'(RST_HOLD - 1))
  ) u_timer (
    .clk_i      (clkin),
    .rst_ni     (resetn),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    slip_d   = slip_q;
    tmr_load = 1'b0;
    tmr_val  = TW'(RST_HOLD - 1);
    if (bus.realign) begin
      state_d  = StHold;
      match_d  = '0;
      slip_d   = '0;
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        StHold: begin
          if (tmr_zero) begin
            state_d  = StSettle;
            tmr_load = 1'b1;
            tmr_val  = TW'(SETTLE - 1);
          end
        end
        StSettle: begin
          if (tmr_zero) begin
            state_d = StCheck;
            match_d = '0;
          end
        end
        StCheck: begin
          if (bus.word_valid) begin
            if (bus.word_in == TRAIN) begin
              if (match_q != MW'(MATCH_CNT)) match_d = match_q + 1'b1;
              if (match_q == MW'(MATCH_CNT - 1)) state_d = StLocked;
            end else if (slip_q == SW'(MAX_SLIP)) begin
              state_d = StFail;
            end else begin
              state_d = StSlip;
            end
          end
        end
        StSlip: begin
          state_d  = StSlipWait;
          slip_d   = slip_q + 1'b1;
          match_d  = '0;
          tmr_load = 1'b1;
          tmr_val  = TW'(SLIP_WAIT - 1);
        end
        StSlipWait: begin
          if (tmr_zero) state_d = StCheck;
        end
        StLocked, StFail: begin
        end
        default: state_d = StHold;
      endcase
    end
  end

  // Outputs are decoded from the next state so each one is a plain register.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StHold;
      match_q  <= '0;
      slip_q   <= '0;
      rstn_q   <= 1'b0;
      calib_q  <= 1'b0;
      locked_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      slip_q   <= slip_d;
      rstn_q   <= (state_d != StHold);
      calib_q  <= (state_d == StSlip);
      locked_q <= (state_d == StLocked);
      fail_q   <= (state_d == StFail);
    end
  end

  assign bus.clkdiv_resetn = rstn_q;
  assign bus.calib         = calib_q;
  assign bus.locked        = locked_q;
  assign bus.fail          = fail_q;
  assign bus.slip_cnt      = slip_q;

endmodule
